dummy_path_driver: RTL
======================

Name: dummy_path_driver

Overview:
- Synthetic DRAM initiator for ASIC power and bring-up tests. It drives the DRAM command and data interface in the same way as the ORAM backend's path access.
- Each access is a path read: NumBuckets*BurstsPerBucket read bursts. The path read is followed by a path writeback of the same burst addresses.
- Read data is XOR-folded into a checksum. Write data is a deterministic pattern.
- The block sits opposite the dummy DRAM responder, or opposite the real memory controller.

Parameters:
- DWidth, 512, width of one data chunk on the read and write data buses.
- AWidth, 30, DRAM command address width.
- NumBuckets, 4, number of buckets per path.
- BurstsPerBucket, 6, DRAM bursts per bucket.
- ChunksPerBurst, 1, data chunks per burst, for both read and write.
- BurstStride, 8, address increment between consecutive bursts.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  pulse that begins one path access. Sampled only in IDLE.
- StartAddress  in  AWidth  base burst address. Latched when Start is accepted.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when the access completes.
- Error  out  1  sticky flag for unexpected read data.
- Checksum  out  DWidth  XOR of all read chunks in the current or last access.
- DRAMCommandValid  out  1  command valid.
- DRAMCommandReady  in  1  command accepted.
- DRAMCommand  out  3  3'b001 = read, 3'b000 = write.
- DRAMCommandAddress  out  AWidth  burst address.
- DRAMReadData  in  DWidth  read chunk.
- DRAMReadDataValid  in  1  read chunk valid. There is no backpressure on this input.
- DRAMWriteData  out  DWidth  write chunk.
- DRAMWriteDataValid  out  1  write chunk valid.
- DRAMWriteDataReady  in  1  write chunk accepted.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
  - Reset returns the FSM to IDLE and clears all counters.
  - Reset values: Busy=0, Done=0, Error=0, Checksum=0, DRAMCommandValid=0, DRAMWriteDataValid=0, DRAMCommand=3'b001, DRAMCommandAddress=0, DRAMWriteData=0.
  - Reset asserted mid-access abandons the access immediately. No Done pulse is produced.
- Definitions:
  - N = NumBuckets*BurstsPerBucket bursts.
  - C = N*ChunksPerBurst chunks.
  - Address of burst i = StartAddress + i*BurstStride, modulo 2^AWidth (wrap is silent).
- Handshake: a command transfers on the cycle where Valid && Ready. Write data uses the same rule.
  - Valid is never dropped and address/data are never changed until the transfer occurs.
- IDLE:
  - Start=1 latches StartAddress, clears Checksum and all counters, and moves to RD_CMD.
  - Start in any other state is ignored.
- RD_CMD:
  - DRAMCommandValid=1, DRAMCommand=read, address of burst rdcmd_cnt.
  - After the N-th accepted command, move to RD_WAIT. If all C chunks have already arrived, move directly to WR.
- Read data:
  - Accepted in RD_CMD and RD_WAIT, including chunks that arrive before all commands are issued.
  - Each valid chunk does Checksum ^= DRAMReadData and increments rd_cnt.
  - A chunk that arrives in IDLE, WR or DONE, or after rd_cnt has reached C, sets Error and is not folded into Checksum.
  - Error clears only on Reset.
- RD_WAIT: when rd_cnt reaches C, including via a chunk arriving this cycle, move to WR on the next cycle.
- WR:
  - Command and data channels run independently. Write data may lead or lag write commands by any amount.
  - Command channel: write commands for bursts 0..N-1, same address sequence as the reads. DRAMCommandValid deasserts once N commands are accepted.
  - Data channel: DRAMWriteDataValid=1 until C chunks are accepted.
  - Write chunk k = the 32-bit value k replicated DWidth/32 times.
  - Move to DONE when both channels are complete. If both complete in the same cycle, move on the next cycle.
- DONE: Done=1 for exactly one cycle, then IDLE. Checksum holds its value until the next accepted Start.
- Counter widths: counters are sized with log2 of C+1. They never wrap within an access.
- Latency: Start to first DRAMCommandValid is 1 cycle. The last write handshake to Done is 1 cycle.

Test Plan:
- Reset mid-access: Reset during RD_CMD after 5 accepted commands -> next cycle Busy=0, DRAMCommandValid=0, Checksum=0. A following Start runs a full access with 24 reads.
- Nominal access: defaults, Ready always 1, responder returns chunk j = j+1 with a 30-cycle delay. Start with StartAddress=0x100 ->
  - 24 reads at 0x100, 0x108, ... 0x1B8.
  - Checksum = XOR of 1..24 = 24.
  - 24 writes at the same addresses, data k replicated.
  - Done pulses once, Error=0.
- Backpressure: DRAMCommandReady random at 30%, DRAMWriteDataReady held 0 for 40 cycles -> no dropped or duplicated command, address held stable while stalled, write data k in order, Done after the last data handshake.
- Early data: read data returned 0 cycles after each command, so all chunks arrive before RD_CMD ends -> FSM skips RD_WAIT into WR, Checksum correct.
- Address wrap: StartAddress = 2^30-16 -> addresses wrap to 0x0, 0x8, ... with no Error.
- Spurious data: DRAMReadDataValid pulsed while IDLE, and a 25th read chunk sent -> Error=1 and stays set, Checksum unchanged by the extra chunks. Start while Busy -> ignored, with no restart.

Source files
------------

// File: rtl/dummy_path_driver.sv
// Synthetic DRAM initiator: one path read of N bursts, then a writeback
// of the same burst addresses; read data is XOR-folded into a checksum.
module dummy_path_driver #(
    parameter int DWidth          = 512,
    parameter int AWidth          = 30,
    parameter int NumBuckets      = 4,
    parameter int BurstsPerBucket = 6,
    parameter int ChunksPerBurst  = 1,
    parameter int BurstStride     = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [AWidth-1:0] StartAddress,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [DWidth-1:0] Checksum,
    output logic              DRAMCommandValid,
    input  logic              DRAMCommandReady,
    output logic [2:0]        DRAMCommand,
    output logic [AWidth-1:0] DRAMCommandAddress,
    input  logic [DWidth-1:0] DRAMReadData,
    input  logic              DRAMReadDataValid,
    output logic [DWidth-1:0] DRAMWriteData,
    output logic              DRAMWriteDataValid,
    input  logic              DRAMWriteDataReady
);
    localparam int N    = NumBuckets * BurstsPerBucket;
    localparam int C    = N * ChunksPerBurst;
    localparam int CntW = $clog2(C + 1);

    localparam logic [CntW-1:0]   One    = CntW'(1);
    localparam logic [CntW-1:0]   NLast  = CntW'(N - 1);
    localparam logic [CntW-1:0]   CLast  = CntW'(C - 1);
    localparam logic [CntW-1:0]   CAll   = CntW'(C);
    localparam logic [AWidth-1:0] Stride = AWidth'(BurstStride);
    localparam logic [2:0]        CmdRd  = 3'b001;
    localparam logic [2:0]        CmdWr  = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        WR,
        DONE
    } state_e;

    state_e            state_q;
    logic [AWidth-1:0] base_q;
    logic [AWidth-1:0] addr_q;
    logic [CntW-1:0]   cmd_cnt_q;
    logic [CntW-1:0]   rd_cnt_q;
    logic [CntW-1:0]   wd_cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              cmd_vld_q;
    logic              wd_vld_q;
    logic [2:0]        cmd_q;
    logic [DWidth-1:0] csum_q;
    logic [DWidth-1:0] wdata_q;

    logic [CntW-1:0]   rd_cnt_d;
    logic [AWidth-1:0] addr_d;
    logic [DWidth-1:0] wdata_d;
    logic              rd_take;
    logic              rd_all;
    logic              cmd_fire;
    logic              cmd_last;
    logic              wd_fire;
    logic              wd_last;
    logic              cmd_fin;
    logic              wd_fin;
    logic              wr_enter;

    function automatic logic [DWidth-1:0] pattern(input logic [CntW-1:0] k);
        return {(DWidth/32){32'(k)}};
    endfunction

    // Chunks are only counted while a read phase is open and not yet full.
    assign rd_take  = DRAMReadDataValid && (rd_cnt_q != CAll) &&
                      (state_q == RD_CMD || state_q == RD_WAIT);
    assign rd_cnt_d = rd_cnt_q + {{(CntW-1){1'b0}}, rd_take};
    assign rd_all   = (rd_cnt_d == CAll);
    assign addr_d   = addr_q + Stride;
    assign wdata_d  = pattern(wd_cnt_q + One);
    assign cmd_fire = cmd_vld_q && DRAMCommandReady;
    assign cmd_last = (cmd_cnt_q == NLast);
    assign wd_fire  = wd_vld_q && DRAMWriteDataReady;
    assign wd_last  = (wd_cnt_q == CLast);
    assign cmd_fin  = !cmd_vld_q || (cmd_fire && cmd_last);
    assign wd_fin   = !wd_vld_q || (wd_fire && wd_last);
    assign wr_enter = rd_all &&
                      ((state_q == RD_WAIT) ||
                       (state_q == RD_CMD && cmd_fire && cmd_last));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            cmd_cnt_q <= '0;
            rd_cnt_q  <= '0;
            wd_cnt_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cmd_vld_q <= 1'b0;
            wd_vld_q  <= 1'b0;
            cmd_q     <= CmdRd;
            csum_q    <= '0;
            wdata_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (DRAMReadDataValid) begin
                if (rd_take) begin
                    csum_q   <= csum_q ^ DRAMReadData;
                    rd_cnt_q <= rd_cnt_d;
                end else begin
                    err_q <= 1'b1;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        base_q    <= StartAddress;
                        addr_q    <= StartAddress;
                        cmd_cnt_q <= '0;
                        rd_cnt_q  <= '0;
                        wd_cnt_q  <= '0;
                        csum_q    <= '0;
                        cmd_vld_q <= 1'b1;
                        cmd_q     <= CmdRd;
                        busy_q    <= 1'b1;
                        state_q   <= RD_CMD;
                    end
                end
                RD_CMD: begin
                    if (cmd_fire) begin
                        cmd_cnt_q <= cmd_cnt_q + One;
                        addr_q    <= addr_d;
                        if (cmd_last) begin
                            cmd_vld_q <= 1'b0;
                            state_q   <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                end
                WR: begin
                    if (cmd_fire) begin
                        cmd_cnt_q <= cmd_cnt_q + One;
                        addr_q    <= addr_d;
                        if (cmd_last) cmd_vld_q <= 1'b0;
                    end
                    if (wd_fire) begin
                        wd_cnt_q <= wd_cnt_q + One;
                        wdata_q  <= wdata_d;
                        if (wd_last) wd_vld_q <= 1'b0;
                    end
                    if (cmd_fin && wd_fin) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // Writeback restarts the address walk from the latched base.
            if (wr_enter) begin
                state_q   <= WR;
                cmd_vld_q <= 1'b1;
                cmd_q     <= CmdWr;
                addr_q    <= base_q;
                cmd_cnt_q <= '0;
                wd_vld_q  <= 1'b1;
                wd_cnt_q  <= '0;
                wdata_q   <= pattern('0);
            end
        end
    end

    assign Busy               = busy_q;
    assign Done               = done_q;
    assign Error              = err_q;
    assign Checksum           = csum_q;
    assign DRAMCommandValid   = cmd_vld_q;
    assign DRAMCommand        = cmd_q;
    assign DRAMCommandAddress = addr_q;
    assign DRAMWriteData      = wdata_q;
    assign DRAMWriteDataValid = wd_vld_q;

endmodule
